spu_ln_ctrl: RTL and testbench

- Sequencer for the SPU LayerNorm datapath: generates the `ln_state`/`sum_en`/`sum_div_cnt`/`sqrt_cnt` control stream and consumes `sum_div_finish`/`sqrt_reci_finish`.
- Drives the activation-buffer read port (two passes per row: statistics, then normalise) and the result-buffer write port.
- Processes `num_rows` rows of `len_words` 32-bit words (4 x int8 each); started by a one-cycle `start` pulse, ends with a one-cycle `done` pulse.

---
 rtl/spu_ln_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_spu_ln_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_ln_ctrl.sv
// -----------------------------------------------------------------------------
// spu_ln_ctrl
//   Sequencer for the SPU LayerNorm datapath. Each row is read twice from the
//   activation buffer. The first pass gathers statistics (SUM_COUNT). The
//   second pass normalises the row (OUT) and writes it to the result buffer.
//   Between the passes the sequencer hands over to the divide (SUM_DIV) and
//   reciprocal-sqrt (SQRT) stages of the datapath.
//
// Ports
//   core_clk, rst_n        clock, asynchronous active-low reset
//   start, abort           job start pulse (IDLE only), synchronous abort
//   len_words, num_rows    row length in 32-bit words, rows per job
//   rd_base, wr_base       first source / destination word address
//   sum_div_finish         datapath divide complete
//   sqrt_reci_finish       datapath reciprocal-sqrt complete
//   ln_state               datapath state (IDLE 000, SUM_COUNT 001,
//                          SUM_DIV 011, SQRT 100, OUT 110)
//   sum_en, sum_div_cnt    accumulate strobe, SUM_DIV phase
//   sqrt_cnt               SQRT cycle counter
//   rd_en, rd_addr         activation-buffer read port (1-cycle latency)
//   wr_en, wr_addr         result-buffer write port
//   busy, done, err        not-IDLE, job-complete pulse, sticky sqrt timeout
// -----------------------------------------------------------------------------
module spu_ln_ctrl #(
    parameter int ADDR_W       = 12,
    parameter int LEN_W        = 10,
    parameter int ROW_W        = 8,
    parameter int SQRT_TIMEOUT = 255
) (
    input  logic              core_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  len_words,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic              sum_div_finish,
    input  logic              sqrt_reci_finish,
    output logic [2:0]        ln_state,
    output logic              sum_en,
    output logic              sum_div_cnt,
    output logic [7:0]        sqrt_cnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // FLUSH is internal only; it is presented to the datapath as OUT.
    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_SUM_COUNT = 3'b001,
        S_SUM_DIV   = 3'b011,
        S_SQRT      = 3'b100,
        S_OUT       = 3'b110,
        S_FLUSH     = 3'b111
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic [2:0]        ln_state_q, ln_state_d;
    logic              sum_en_q, sum_en_d;
    logic              sum_div_cnt_q, sum_div_cnt_d;
    logic [7:0]        sqrt_cnt_q, sqrt_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              abort_s;

    // State, latched configuration and registered outputs.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            rows_q        <= '0;
            row_q         <= '0;
            rd_base_q     <= '0;
            wr_base_q     <= '0;
            row_off_q     <= '0;
            ln_state_q    <= 3'b000;
            sum_en_q      <= 1'b0;
            sum_div_cnt_q <= 1'b0;
            sqrt_cnt_q    <= 8'd0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            rows_q        <= rows_d;
            row_q         <= row_d;
            rd_base_q     <= rd_base_d;
            wr_base_q     <= wr_base_d;
            row_off_q     <= row_off_d;
            ln_state_q    <= ln_state_d;
            sum_en_q      <= sum_en_d;
            sum_div_cnt_q <= sum_div_cnt_d;
            sqrt_cnt_q    <= sqrt_cnt_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Next-state sequencing, then outputs derived from the next state so they
    // leave the flops already aligned with ln_state.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        rows_d        = rows_q;
        row_d         = row_q;
        rd_base_d     = rd_base_q;
        wr_base_d     = wr_base_q;
        row_off_d     = row_off_q;
        sum_div_cnt_d = sum_div_cnt_q;
        sqrt_cnt_d    = sqrt_cnt_q;
        done_d        = 1'b0;
        err_d         = err_q;
        abort_s       = abort && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = len_words;
                    rows_d    = num_rows;
                    rd_base_d = rd_base;
                    wr_base_d = wr_base;
                    row_off_d = '0;
                    row_d     = '0;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    if ((len_words == '0) || (num_rows == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_SUM_COUNT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SUM_COUNT: begin
                // The extra idx==len cycle lets the last sum_en land first.
                if (idx_q == len_q) begin
                    idx_d         = '0;
                    sum_div_cnt_d = 1'b0;
                    state_d       = S_SUM_DIV;
                end else begin
                    idx_d = idx_q + LEN_W'(1'b1);
                end
            end
            S_SUM_DIV: begin
                if (sum_div_cnt_q == 1'b0) begin
                    sum_div_cnt_d = 1'b1;
                end else if (sum_div_finish) begin
                    sum_div_cnt_d = 1'b0;
                    sqrt_cnt_d    = 8'd0;
                    state_d       = S_SQRT;
                end else begin
                    sum_div_cnt_d = 1'b1;
                end
            end
            S_SQRT: begin
                // A finish in the timeout cycle still counts as success.
                if (sqrt_reci_finish) begin
                    sqrt_cnt_d = 8'd0;
                    idx_d      = '0;
                    state_d    = S_OUT;
                end else if (sqrt_cnt_q == 8'(SQRT_TIMEOUT)) begin
                    sqrt_cnt_d = 8'd0;
                    err_d      = 1'b1;
                    state_d    = S_FLUSH;
                end else begin
                    sqrt_cnt_d = sqrt_cnt_q + 8'd1;
                end
            end
            S_OUT: begin
                if (idx_q == len_q) begin
                    idx_d     = '0;
                    row_off_d = row_off_q + ADDR_W'(len_q);
                    row_d     = row_q + ROW_W'(1'b1);
                    if (row_d == rows_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SUM_COUNT;
                    end
                end else begin
                    idx_d = idx_q + LEN_W'(1'b1);
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_s) begin
            state_d       = S_FLUSH;
            idx_d         = '0;
            sum_div_cnt_d = 1'b0;
            sqrt_cnt_d    = 8'd0;
            done_d        = 1'b0;
        end else begin
            state_d = state_d;
        end

        ln_state_d = (state_d == S_FLUSH) ? 3'b110 : state_d;
        busy_d     = (state_d != S_IDLE);
        rd_en_d    = ((state_d == S_SUM_COUNT) || (state_d == S_OUT)) && (idx_d < len_d);
        rd_addr_d  = rd_en_d ? (rd_base_d + row_off_d + ADDR_W'(idx_d)) : '0;
        // Reads issued this cycle become accumulate strobes or writes next cycle.
        sum_en_d   = rd_en_q && (state_q == S_SUM_COUNT) && !abort_s;
        wr_en_d    = rd_en_q && (state_q == S_OUT) && !abort_s;
        wr_addr_d  = wr_en_d ? (wr_base_q + row_off_q + ADDR_W'(idx_q)) : '0;
    end

    assign ln_state    = ln_state_q;
    assign sum_en      = sum_en_q;
    assign sum_div_cnt = sum_div_cnt_q;
    assign sqrt_cnt    = sqrt_cnt_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_spu_ln_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spu_ln_ctrl
//   Directed bench for spu_ln_ctrl. A small datapath responder answers the
//   SUM_DIV and SQRT handshakes; a negedge monitor logs the buffer traffic and
//   per-state cycle counts that the scenario tasks compare with hand-derived
//   expectations.
// -----------------------------------------------------------------------------
module tb_spu_ln_ctrl;

    logic        core_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  len_words = 10'd0;
    logic [7:0]  num_rows = 8'd0;
    logic [11:0] rd_base = 12'd0;
    logic [11:0] wr_base = 12'd0;
    logic        sum_div_finish = 1'b0;
    logic        sqrt_reci_finish = 1'b0;
    logic [2:0]  ln_state;
    logic        sum_en;
    logic        sum_div_cnt;
    logic [7:0]  sqrt_cnt;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    // responder control
    bit         fin_enable = 1'b1;
    logic [7:0] fin_at = 8'd6;

    // monitor logs
    logic [11:0] rd_log[$];
    logic [11:0] wr_log[$];
    int done_cnt, busy_cnt, sum_en_cnt, lag_bad, sumdiv_cyc, sqrt_cyc, sqrt_max;
    int sqrt_stray, out_cyc, quiet_out, sc_entries;
    bit prev_rd_sc;
    logic [2:0] prev_state;

    spu_ln_ctrl dut (
        .core_clk(core_clk), .rst_n(rst_n), .start(start), .abort(abort),
        .len_words(len_words), .num_rows(num_rows), .rd_base(rd_base),
        .wr_base(wr_base), .sum_div_finish(sum_div_finish),
        .sqrt_reci_finish(sqrt_reci_finish), .ln_state(ln_state),
        .sum_en(sum_en), .sum_div_cnt(sum_div_cnt), .sqrt_cnt(sqrt_cnt),
        .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 core_clk = ~core_clk;

    // Datapath model: divide completes in the second SUM_DIV cycle, sqrt at fin_at.
    initial begin
        forever begin
            @(negedge core_clk);
            sum_div_finish = (ln_state == 3'b011) && (sum_div_cnt == 1'b1);
            sqrt_reci_finish = fin_enable && (ln_state == 3'b100) && (sqrt_cnt == fin_at);
        end
    end

    // Traffic and state monitor.
    initial begin
        forever begin
            @(negedge core_clk);
            if (rd_en) rd_log.push_back(rd_addr);
            if (wr_en) wr_log.push_back(wr_addr);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (sum_en) sum_en_cnt++;
            if (sum_en !== prev_rd_sc) lag_bad++;
            prev_rd_sc = rd_en && (ln_state == 3'b001);
            if (ln_state == 3'b011) sumdiv_cyc++;
            if (ln_state == 3'b100) begin
                sqrt_cyc++;
                if (int'(sqrt_cnt) > sqrt_max) sqrt_max = int'(sqrt_cnt);
            end else if (sqrt_cnt != 8'd0) begin
                sqrt_stray++;
            end
            if (ln_state == 3'b110) out_cyc++;
            if (ln_state == 3'b110 && !rd_en && !wr_en && !sum_en) quiet_out++;
            if (ln_state == 3'b001 && prev_state != 3'b001) sc_entries++;
            prev_state = ln_state;
        end
    end

    task automatic clear_logs();
        rd_log.delete(); wr_log.delete();
        done_cnt = 0; busy_cnt = 0; sum_en_cnt = 0; lag_bad = 0; sumdiv_cyc = 0;
        sqrt_cyc = 0; sqrt_max = 0; sqrt_stray = 0; out_cyc = 0; quiet_out = 0;
        sc_entries = 0; prev_rd_sc = 1'b0; prev_state = ln_state;
    endtask

    // Pulses start for one cycle; returns at posedge+1 of the first cycle after acceptance.
    task automatic launch(input logic [9:0] l, input logic [7:0] r,
                          input logic [11:0] rb, input logic [11:0] wb);
        @(posedge core_clk); #1;
        clear_logs();
        len_words = l; num_rows = r; rd_base = rb; wr_base = wb; start = 1'b1;
        @(posedge core_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge core_clk); #1;
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, expected 0", name, busy, n);
        end
        @(negedge core_clk); #1;
    endtask

    task automatic test_reset();
        logic [41:0] outs;
        #3 rst_n = 1'b0;
        #1;
        outs = {ln_state, sum_en, sum_div_cnt, sqrt_cnt, rd_en, rd_addr, wr_en, wr_addr, busy, done, err};
        checks++;
        if (outs !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        repeat (3) @(posedge core_clk);
        @(negedge core_clk); rst_n = 1'b1;
        @(posedge core_clk); #1;
        checks++;
        if (ln_state !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: ln_state=%b busy=%b expected 000/0", ln_state, busy);
        end
    endtask

    task automatic test_single_row();
        logic [11:0] exp;
        fin_enable = 1'b1; fin_at = 8'd6;
        launch(10'd4, 8'd1, 12'h010, 12'h200);
        wait_idle(60, "single");
        checks++;
        if (rd_log.size() != 8) begin failures++; $display("FAIL single_rd_count: got %0d expected 8", rd_log.size()); end
        for (int i = 0; i < 8; i++) begin
            exp = 12'h010 + 12'(i % 4);
            checks++;
            if (i >= rd_log.size() || rd_log[i] !== exp) begin
                failures++;
                $display("FAIL single_rd_addr[%0d]: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 12'hxxx, exp);
            end
        end
        checks++;
        if (wr_log.size() != 4) begin failures++; $display("FAIL single_wr_count: got %0d expected 4", wr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = 12'h200 + 12'(i);
            checks++;
            if (i >= wr_log.size() || wr_log[i] !== exp) begin
                failures++;
                $display("FAIL single_wr_addr[%0d]: got %h expected %h", i, (i < wr_log.size()) ? wr_log[i] : 12'hxxx, exp);
            end
        end
        checks++;
        if (sum_en_cnt != 4 || lag_bad != 0) begin
            failures++; $display("FAIL single_sum_en: cycles=%0d lag_errors=%0d expected 4/0", sum_en_cnt, lag_bad);
        end
        checks++;
        if (sumdiv_cyc != 2) begin failures++; $display("FAIL single_sum_div: got %0d cycles expected 2", sumdiv_cyc); end
        checks++;
        if (sqrt_cyc != 7 || sqrt_max != 6 || sqrt_stray != 0) begin
            failures++; $display("FAIL single_sqrt: cycles=%0d max=%0d stray=%0d expected 7/6/0", sqrt_cyc, sqrt_max, sqrt_stray);
        end
        checks++;
        if (busy_cnt != 19) begin failures++; $display("FAIL single_latency: got %0d busy cycles expected 19", busy_cnt); end
        checks++;
        if (done_cnt != 1 || err !== 1'b0) begin
            failures++; $display("FAIL single_done: done=%0d err=%b expected 1/0", done_cnt, err);
        end
    endtask

    task automatic test_multi_row();
        logic [11:0] exp;
        fin_enable = 1'b1; fin_at = 8'd2;
        launch(10'd3, 8'd3, 12'h100, 12'h300);
        wait_idle(120, "multi");
        checks++;
        if (rd_log.size() != 18) begin failures++; $display("FAIL multi_rd_count: got %0d expected 18", rd_log.size()); end
        for (int i = 0; i < 18; i++) begin
            exp = 12'h100 + 12'(3 * (i / 6)) + 12'(i % 3);
            checks++;
            if (i >= rd_log.size() || rd_log[i] !== exp) begin
                failures++;
                $display("FAIL multi_rd_addr[%0d]: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 12'hxxx, exp);
            end
        end
        for (int i = 0; i < 9; i++) begin
            exp = 12'h300 + 12'(i);
            checks++;
            if (i >= wr_log.size() || wr_log[i] !== exp) begin
                failures++;
                $display("FAIL multi_wr_addr[%0d]: got %h expected %h", i, (i < wr_log.size()) ? wr_log[i] : 12'hxxx, exp);
            end
        end
        checks++;
        if (sc_entries != 3 || done_cnt != 1 || busy_cnt != 39) begin
            failures++;
            $display("FAIL multi_rows: sum_count_entries=%0d done=%0d busy=%0d expected 3/1/39", sc_entries, done_cnt, busy_cnt);
        end
    endtask

    task automatic test_timeout();
        fin_enable = 1'b0;
        launch(10'd1, 8'd1, 12'h000, 12'h400);
        wait_idle(400, "timeout");
        checks++;
        if (sqrt_max != 255 || sqrt_cyc != 256) begin
            failures++; $display("FAIL timeout_sqrt: max=%0d cycles=%0d expected 255/256", sqrt_max, sqrt_cyc);
        end
        checks++;
        if (err !== 1'b1 || done_cnt != 0) begin
            failures++; $display("FAIL timeout_err: err=%b done=%0d expected 1/0", err, done_cnt);
        end
        checks++;
        if (out_cyc != 1 || quiet_out != 1 || wr_log.size() != 0 || busy_cnt != 261) begin
            failures++;
            $display("FAIL timeout_flush: out=%0d quiet=%0d writes=%0d busy=%0d expected 1/1/0/261", out_cyc, quiet_out, wr_log.size(), busy_cnt);
        end
        fin_enable = 1'b1; fin_at = 8'd0;
        launch(10'd1, 8'd1, 12'h000, 12'h400);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: err=%b expected 0", err); end
        wait_idle(40, "timeout_restart");
    endtask

    task automatic test_abort();
        int writes = 0;
        int n = 0;
        fin_enable = 1'b1; fin_at = 8'd1;
        launch(10'd8, 8'd1, 12'h020, 12'h040);
        while (writes < 2 && n < 100) begin
            @(posedge core_clk); #1;
            n++;
            if (wr_en) writes++;
        end
        checks++;
        if (writes != 2) begin failures++; $display("FAIL abort_reach_out: writes=%0d expected 2", writes); end
        abort = 1'b1;
        @(posedge core_clk); #1;
        abort = 1'b0;
        checks++;
        if (ln_state !== 3'b110 || wr_en !== 1'b0 || rd_en !== 1'b0 || sum_en !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_flush: ln_state=%b wr_en=%b rd_en=%b sum_en=%b busy=%b expected 110/0/0/0/1", ln_state, wr_en, rd_en, sum_en, busy);
        end
        @(posedge core_clk); #1;
        checks++;
        if (ln_state !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_idle: ln_state=%b busy=%b done=%b expected 000/0/0", ln_state, busy, done);
        end
        @(negedge core_clk); #1;
        checks++;
        if (wr_log.size() != 2 || done_cnt != 0) begin
            failures++; $display("FAIL abort_writes: writes=%0d done=%0d expected 2/0", wr_log.size(), done_cnt);
        end
    endtask

    task automatic test_degenerate_and_ignored();
        launch(10'd0, 8'd2, 12'h010, 12'h020);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ln_state !== 3'b000) begin
            failures++; $display("FAIL empty_len_done: done=%b busy=%b ln_state=%b expected 1/0/000", done, busy, ln_state);
        end
        repeat (3) @(posedge core_clk);
        #1;
        checks++;
        if (done !== 1'b0 || rd_log.size() != 0 || done_cnt != 1) begin
            failures++; $display("FAIL empty_len_after: done=%b reads=%0d pulses=%0d expected 0/0/1", done, rd_log.size(), done_cnt);
        end
        launch(10'd5, 8'd0, 12'h010, 12'h020);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL empty_rows_done: done=%b busy=%b expected 1/0", done, busy);
        end
        // start during SQRT must not disturb the running job
        fin_enable = 1'b1; fin_at = 8'd20;
        launch(10'd2, 8'd1, 12'h050, 12'h060);
        for (int i = 0; i < 50 && ln_state !== 3'b100; i++) begin
            @(posedge core_clk); #1;
        end
        len_words = 10'd7; rd_base = 12'h0AA; wr_base = 12'h0BB; start = 1'b1;
        @(posedge core_clk); #1;
        start = 1'b0;
        checks++;
        if (ln_state !== 3'b100 || sqrt_cnt !== 8'd1) begin
            failures++; $display("FAIL ignored_start_state: ln_state=%b sqrt_cnt=%0d expected 100/1", ln_state, sqrt_cnt);
        end
        wait_idle(80, "ignored_start");
        checks++;
        if (rd_log.size() != 4 || wr_log.size() != 2 || done_cnt != 1) begin
            failures++; $display("FAIL ignored_start_counts: reads=%0d writes=%0d done=%0d expected 4/2/1", rd_log.size(), wr_log.size(), done_cnt);
        end else begin
            checks++;
            if (rd_log[2] !== 12'h050 || rd_log[3] !== 12'h051 || wr_log[1] !== 12'h061) begin
                failures++; $display("FAIL ignored_start_addr: rd=%h,%h wr=%h expected 050,051 061", rd_log[2], rd_log[3], wr_log[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        fin_enable = 1'b1; fin_at = 8'd0;
        launch(10'd1, 8'd1, 12'h010, 12'h020);
        while (!done && n < 40) begin
            @(posedge core_clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: done=%b expected 1", done); end
        len_words = 10'd2; num_rows = 8'd1; rd_base = 12'h070; wr_base = 12'h080; start = 1'b1;
        @(posedge core_clk); #1;
        start = 1'b0;
        checks++;
        if (ln_state !== 3'b001 || rd_en !== 1'b1 || rd_addr !== 12'h070 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: ln_state=%b rd_en=%b rd_addr=%h busy=%b expected 001/1/070/1", ln_state, rd_en, rd_addr, busy);
        end
        wait_idle(40, "b2b");
    endtask

    task automatic test_async_reset();
        fin_enable = 1'b1; fin_at = 8'd3;
        launch(10'd4, 8'd1, 12'h010, 12'h200);
        @(posedge core_clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ln_state, sum_en, sum_div_cnt, sqrt_cnt, rd_en, rd_addr, wr_en, wr_addr, busy, done, err} !== 42'd0) begin
            failures++; $display("FAIL async_reset: ln_state=%b rd_en=%b rd_addr=%h busy=%b expected all 0", ln_state, rd_en, rd_addr, busy);
        end
        @(negedge core_clk); rst_n = 1'b1;
        repeat (2) @(posedge core_clk);
        #1;
        checks++;
        if (busy !== 1'b0 || ln_state !== 3'b000 || rd_en !== 1'b0) begin
            failures++; $display("FAIL async_reset_no_resume: busy=%b ln_state=%b rd_en=%b expected 0/000/0", busy, ln_state, rd_en);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_multi_row();
        test_timeout();
        test_abort();
        test_degenerate_and_ignored();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
